// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register busy scoreboard.
// Combinational reads with optional same-cycle write forwarding; two write ports, port 2 wins.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_RD*AW-1:0]     RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     Write1,
    input  logic [AW-1:0]            WriteReg1,
    input  logic [DATA_W-1:0]        WriteData1,
    input  logic                     Write2,
    input  logic [AW-1:0]            WriteReg2,
    input  logic [DATA_W-1:0]        WriteData2,
    input  logic                     Issue,
    input  logic [AW-1:0]            IssueReg,
    input  logic                     Flush
);

    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    logic [NUM_REGS-1:0][DATA_W-1:0] regArray_r;
    logic [NUM_REGS-1:0][DATA_W-1:0] regNext_s;
    logic [NUM_REGS-1:0]             busy_r;
    logic [NUM_REGS-1:0]             busyNext_s;
    logic                            wrEn1_s;
    logic                            wrEn2_s;
    logic                            issEn_s;

    // Register 0 is hardwired when ZERO_REG is set, so its writes and issues are masked here.
    assign wrEn1_s = Write1 & ~(ZERO_REG & (WriteReg1 == ZERO_ADDR));
    assign wrEn2_s = Write2 & ~(ZERO_REG & (WriteReg2 == ZERO_ADDR));
    assign issEn_s = Issue  & ~(ZERO_REG & (IssueReg  == ZERO_ADDR));

    // Next-state array and scoreboard: port 2 over port 1, flush over issue, issue over write-clear.
    always_comb begin
        regNext_s  = regArray_r;
        busyNext_s = busy_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            regNext_s[r] = (wrEn2_s && (WriteReg2 == AW'(r))) ? WriteData2 :
                           (wrEn1_s && (WriteReg1 == AW'(r))) ? WriteData1 :
                           regArray_r[r];
            busyNext_s[r] = Flush                                   ? 1'b0 :
                            (issEn_s && (IssueReg == AW'(r)))       ? 1'b1 :
                            ((wrEn1_s && (WriteReg1 == AW'(r))) ||
                             (wrEn2_s && (WriteReg2 == AW'(r))))    ? 1'b0 :
                            busy_r[r];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            regArray_r <= {(NUM_REGS*DATA_W){1'b0}};
            busy_r     <= {NUM_REGS{1'b0}};
        end else begin
            regArray_r <= regNext_s;
            busy_r     <= busyNext_s;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRd
        logic [AW-1:0]     addr_s;
        logic              hit1_s;
        logic              hit2_s;
        logic              hitIss_s;
        logic              isZero_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s   = RdAddr[k*AW +: AW];
        assign hit1_s   = wrEn1_s  & (WriteReg1 == addr_s);
        assign hit2_s   = wrEn2_s  & (WriteReg2 == addr_s);
        assign hitIss_s = issEn_s  & (IssueReg  == addr_s);
        assign isZero_s = ZERO_REG & (addr_s == ZERO_ADDR);

        // Read mux; forwarding is gated by reset so a held write cannot leak out.
        always_comb begin
            if (!RESET || isZero_s) begin
                data_s = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else begin
                if (BYPASS && hit2_s) begin
                    data_s = WriteData2;
                end else if (BYPASS && hit1_s) begin
                    data_s = WriteData1;
                end else begin
                    data_s = regArray_r[addr_s];
                end
                if (BYPASS && (hit1_s || hit2_s) && !hitIss_s) begin
                    busy_s = 1'b0;
                end else begin
                    busy_s = busy_r[addr_s];
                end
            end
        end

        assign RdData[k*DATA_W +: DATA_W] = data_s;
        assign RdBusy[k]                  = busy_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding instance and a non-forwarding instance share stimulus.
module tb_regfile_mp;

    logic        CLK;
    logic        RESET;
    logic [14:0] RdAddr;
    logic        Write1, Write2, Issue, Flush;
    logic [4:0]  WriteReg1, WriteReg2, IssueReg;
    logic [31:0] WriteData1, WriteData2;
    logic [95:0] rdDataB, rdDataN;
    logic [2:0]  rdBusyB, rdBusyN;

    int checks;
    int failures;

    regfile_mp #(.BYPASS(1'b1)) dutB (
        .CLK(CLK), .RESET(RESET), .RdAddr(RdAddr), .RdData(rdDataB), .RdBusy(rdBusyB),
        .Write1(Write1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
        .Write2(Write2), .WriteReg2(WriteReg2), .WriteData2(WriteData2),
        .Issue(Issue), .IssueReg(IssueReg), .Flush(Flush)
    );

    regfile_mp #(.BYPASS(1'b0)) dutN (
        .CLK(CLK), .RESET(RESET), .RdAddr(RdAddr), .RdData(rdDataN), .RdBusy(rdBusyN),
        .Write1(Write1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
        .Write2(Write2), .WriteReg2(WriteReg2), .WriteData2(WriteData2),
        .Issue(Issue), .IssueReg(IssueReg), .Flush(Flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rdB(input int k);
        return rdDataB[k*32 +: 32];
    endfunction

    function automatic logic [31:0] rdN(input int k);
        return rdDataN[k*32 +: 32];
    endfunction

    task automatic setAddr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        RdAddr = {a2, a1, a0};
    endtask

    task automatic idle();
        Write1 = 1'b0; WriteReg1 = 5'd0; WriteData1 = 32'h0;
        Write2 = 1'b0; WriteReg2 = 5'd0; WriteData2 = 32'h0;
        Issue  = 1'b0; IssueReg  = 5'd0; Flush = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        idle();
        setAddr(5'd0, 5'd5, 5'd31);
        Write1 = 1'b1; WriteReg1 = 5'd5; WriteData1 = 32'hCAFEF00D;
        Issue = 1'b1; IssueReg = 5'd5;
        #2;
        checks++;
        if (rdDataB !== 96'h0) begin
            failures++; $display("FAIL reset_data_b got=%h exp=0", rdDataB);
        end
        checks++;
        if (rdDataN !== 96'h0) begin
            failures++; $display("FAIL reset_data_n got=%h exp=0", rdDataN);
        end
        checks++;
        if (rdBusyB !== 3'b000 || rdBusyN !== 3'b000) begin
            failures++; $display("FAIL reset_busy got=%b/%b exp=000", rdBusyB, rdBusyN);
        end
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        idle();
        #1;
        checks++;
        if (rdB(1) !== 32'h0 || rdN(1) !== 32'h0) begin
            failures++; $display("FAIL reset_write_ignored got=%h/%h exp=0", rdB(1), rdN(1));
        end
        @(negedge CLK);
        #1;
        checks++;
        if (rdDataB !== 96'h0 || rdBusyB !== 3'b000) begin
            failures++; $display("FAIL post_reset got=%h busy=%b exp=0", rdDataB, rdBusyB);
        end
    endtask

    task automatic test_bypass();
        @(negedge CLK);
        setAddr(5'd5, 5'd0, 5'd0);
        Write1 = 1'b1; WriteReg1 = 5'd5; WriteData1 = 32'hDEADBEEF;
        #1;
        checks++;
        if (rdB(0) !== 32'hDEADBEEF) begin
            failures++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rdB(0));
        end
        checks++;
        if (rdN(0) !== 32'h0) begin
            failures++; $display("FAIL nobypass_same_cycle got=%h exp=0", rdN(0));
        end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdB(0) !== 32'hDEADBEEF || rdN(0) !== 32'hDEADBEEF) begin
            failures++; $display("FAIL write_commit got=%h/%h exp=deadbeef", rdB(0), rdN(0));
        end
    endtask

    task automatic test_dual_write();
        @(negedge CLK);
        setAddr(5'd7, 5'd7, 5'd5);
        Write1 = 1'b1; WriteReg1 = 5'd7; WriteData1 = 32'h11111111;
        Write2 = 1'b1; WriteReg2 = 5'd7; WriteData2 = 32'h22222222;
        #1;
        checks++;
        if (rdB(1) !== 32'h22222222) begin
            failures++; $display("FAIL dual_bypass_priority got=%h exp=22222222", rdB(1));
        end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdB(0) !== 32'h22222222 || rdN(0) !== 32'h22222222) begin
            failures++; $display("FAIL dual_write_store got=%h/%h exp=22222222", rdB(0), rdN(0));
        end
        checks++;
        if (rdB(2) !== 32'hDEADBEEF) begin
            failures++; $display("FAIL dual_write_other got=%h exp=deadbeef", rdB(2));
        end
        // Distinct addresses on both ports in one cycle.
        @(negedge CLK);
        setAddr(5'd12, 5'd13, 5'd7);
        Write1 = 1'b1; WriteReg1 = 5'd12; WriteData1 = 32'hA5A5A5A5;
        Write2 = 1'b1; WriteReg2 = 5'd13; WriteData2 = 32'h5A5A5A5A;
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdN(0) !== 32'hA5A5A5A5 || rdN(1) !== 32'h5A5A5A5A) begin
            failures++; $display("FAIL two_port_write got=%h/%h exp=a5a5a5a5/5a5a5a5a", rdN(0), rdN(1));
        end
    endtask

    task automatic test_zero_reg();
        @(negedge CLK);
        setAddr(5'd0, 5'd0, 5'd0);
        Write1 = 1'b1; WriteReg1 = 5'd0; WriteData1 = 32'hFFFFFFFF;
        Write2 = 1'b1; WriteReg2 = 5'd0; WriteData2 = 32'hFFFFFFFF;
        Issue = 1'b1; IssueReg = 5'd0;
        #1;
        checks++;
        if (rdDataB !== 96'h0 || rdBusyB !== 3'b000) begin
            failures++; $display("FAIL zero_same_cycle got=%h busy=%b exp=0", rdDataB, rdBusyB);
        end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdDataB !== 96'h0 || rdDataN !== 96'h0) begin
            failures++; $display("FAIL zero_after_write got=%h/%h exp=0", rdDataB, rdDataN);
        end
        checks++;
        if (rdBusyB !== 3'b000 || rdBusyN !== 3'b000) begin
            failures++; $display("FAIL zero_busy got=%b/%b exp=000", rdBusyB, rdBusyN);
        end
    endtask

    task automatic test_busy();
        @(negedge CLK);
        setAddr(5'd9, 5'd10, 5'd9);
        Issue = 1'b1; IssueReg = 5'd9;
        #1;
        checks++;
        if (rdBusyB[0] !== 1'b0) begin
            failures++; $display("FAIL busy_before_edge got=%b exp=0", rdBusyB[0]);
        end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdBusyB !== 3'b101 || rdBusyN !== 3'b101) begin
            failures++; $display("FAIL busy_set got=%b/%b exp=101", rdBusyB, rdBusyN);
        end
        Write2 = 1'b1; WriteReg2 = 5'd9; WriteData2 = 32'h99999999;
        Issue = 1'b1; IssueReg = 5'd9;
        #1;
        checks++;
        if (rdBusyB[0] !== 1'b1) begin
            failures++; $display("FAIL busy_issue_write_same got=%b exp=1", rdBusyB[0]);
        end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdBusyB[0] !== 1'b1 || rdN(0) !== 32'h99999999) begin
            failures++; $display("FAIL busy_new_producer got=%b data=%h exp=1/99999999", rdBusyB[0], rdN(0));
        end
        Write1 = 1'b1; WriteReg1 = 5'd9; WriteData1 = 32'h00000009;
        #1;
        checks++;
        if (rdBusyB[0] !== 1'b0 || rdBusyN[0] !== 1'b1) begin
            failures++; $display("FAIL busy_write_bypass got=%b/%b exp=0/1", rdBusyB[0], rdBusyN[0]);
        end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdBusyB[0] !== 1'b0 || rdBusyN[0] !== 1'b0) begin
            failures++; $display("FAIL busy_clear got=%b/%b exp=0/0", rdBusyB[0], rdBusyN[0]);
        end
        Issue = 1'b1; IssueReg = 5'd9;
        @(negedge CLK);
        idle();
        Flush = 1'b1; Issue = 1'b1; IssueReg = 5'd10;
        #1;
        checks++;
        if (rdBusyB !== 3'b101) begin
            failures++; $display("FAIL busy_before_flush got=%b exp=101", rdBusyB);
        end
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdBusyB !== 3'b000 || rdBusyN !== 3'b000) begin
            failures++; $display("FAIL flush got=%b/%b exp=000", rdBusyB, rdBusyN);
        end
        checks++;
        if (rdN(0) !== 32'h00000009) begin
            failures++; $display("FAIL flush_keeps_data got=%h exp=00000009", rdN(0));
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        setAddr(5'd3, 5'd7, 5'd3);
        Write1 = 1'b1; WriteReg1 = 5'd3; WriteData1 = 32'h12345678;
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdN(0) !== 32'h12345678) begin
            failures++; $display("FAIL async_pre got=%h exp=12345678", rdN(0));
        end
        Write1 = 1'b1; WriteReg1 = 5'd3; WriteData1 = 32'hAAAA5555;
        Issue = 1'b1; IssueReg = 5'd3;
        #1;
        RESET = 1'b0;
        #1;
        checks++;
        if (rdDataB !== 96'h0 || rdDataN !== 96'h0) begin
            failures++; $display("FAIL async_clear got=%h/%h exp=0", rdDataB, rdDataN);
        end
        checks++;
        if (rdBusyB !== 3'b000) begin
            failures++; $display("FAIL async_busy got=%b exp=000", rdBusyB);
        end
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        idle();
        #1;
        checks++;
        if (rdN(0) !== 32'h0 || rdN(1) !== 32'h0 || rdBusyN !== 3'b000) begin
            failures++; $display("FAIL async_discard got=%h/%h busy=%b exp=0", rdN(0), rdN(1), rdBusyN);
        end
        Write2 = 1'b1; WriteReg2 = 5'd3; WriteData2 = 32'h0BADF00D;
        @(negedge CLK);
        idle();
        #1;
        checks++;
        if (rdN(0) !== 32'h0BADF00D) begin
            failures++; $display("FAIL first_commit_after_reset got=%h exp=0badf00d", rdN(0));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_bypass();
        test_dual_write();
        test_zero_reg();
        test_busy();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
